// File: rtl/fgyrus_res_reader.sv
`default_nettype none
// ============================================================================
// Module      : fgyrus_res_reader
// Description : Reads one frame of FFT result bins from the FFT Res RAM in
//               ascending address order. Streams the bins out through a
//               2-entry valid/ready buffer and tracks the peak bin of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fgyrus_res_reader #(
    parameter int P_32B_W              = 32,
    parameter int P_FFT_RES_RAM_ADDR_W = 7,
    parameter int P_NUM_BINS           = 128
) (
    input  logic                            clk_ir,
    input  logic                            rst_ih,
    input  logic                            start_ih,
    output logic [P_FFT_RES_RAM_ADDR_W-1:0] fft_res_rd_addr_od,
    output logic                            fft_res_rd_en_oh,
    input  logic [P_32B_W-1:0]              fft_res_rd_data_id,
    output logic [P_32B_W-1:0]              bin_data_od,
    output logic [P_FFT_RES_RAM_ADDR_W-1:0] bin_idx_od,
    output logic                            bin_valid_oh,
    input  logic                            bin_ready_ih,
    output logic                            bin_last_oh,
    output logic                            busy_oh,
    output logic                            done_oh,
    output logic [P_FFT_RES_RAM_ADDR_W-1:0] peak_idx_od,
    output logic [P_32B_W-1:0]              peak_val_od
);

    localparam int AW = P_FFT_RES_RAM_ADDR_W;
    localparam int DW = P_32B_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(P_NUM_BINS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   issue_ptr;   // address of the next read to issue
    logic [AW-1:0]   last_addr;   // last address actually issued
    logic            pend;        // a read was issued last cycle; its data is on the bus now
    logic [AW-1:0]   pend_idx;    // bin index of the data on the bus

    logic [DW-1:0]   fifo_data [2];
    logic [AW-1:0]   fifo_idx  [2];
    logic [1:0]      fifo_last;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      fifo_count;

    logic [DW-1:0]   run_val;
    logic [AW-1:0]   run_idx;

    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      committed;
    logic            head_last;
    logic            head_gt;

    // Read issue is decided combinationally so this cycle's pop frees a slot
    // immediately; that is what allows one bin per cycle with a 2-deep buffer.
    always_comb begin
        pop       = (fifo_count != 2'd0) && bin_ready_ih;
        push      = pend;
        committed = {1'b0, fifo_count} + {2'b00, pend} - {2'b00, pop};
        issue     = (state == ST_READ) && (committed < 3'd2);
        head_last = fifo_last[rd_ptr];
        head_gt   = fifo_data[rd_ptr] > run_val;
    end

    assign fft_res_rd_en_oh   = issue;
    assign fft_res_rd_addr_od = issue ? issue_ptr : last_addr;

    // Outputs are forced to zero when empty so stale entries never show.
    assign bin_valid_oh = (fifo_count != 2'd0);
    assign bin_data_od  = bin_valid_oh ? fifo_data[rd_ptr] : '0;
    assign bin_idx_od   = bin_valid_oh ? fifo_idx[rd_ptr]  : '0;
    assign bin_last_oh  = bin_valid_oh & head_last;
    assign busy_oh      = (state != ST_IDLE);

    // Frame control: read sequencing, in-flight tracking and done pulse.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            state     <= ST_IDLE;
            issue_ptr <= '0;
            last_addr <= '0;
            pend      <= 1'b0;
            pend_idx  <= '0;
            done_oh   <= 1'b0;
        end else begin
            done_oh <= 1'b0;
            pend    <= issue;
            if (issue) begin
                pend_idx  <= issue_ptr;
                last_addr <= issue_ptr;
            end
            case (state)
                ST_IDLE: begin
                    if (start_ih) begin
                        state     <= ST_READ;
                        issue_ptr <= '0;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (issue_ptr == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            issue_ptr <= issue_ptr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_last) begin
                        state   <= ST_IDLE;
                        done_oh <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry output buffer; RAM data is captured the cycle after its read.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            fifo_last  <= 2'b00;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= fft_res_rd_data_id;
                fifo_idx[wr_ptr]  <= pend_idx;
                fifo_last[wr_ptr] <= (pend_idx == LAST_IDX);
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Peak tracking over transferred bins; published only with done.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            run_val     <= '0;
            run_idx     <= '0;
            peak_val_od <= '0;
            peak_idx_od <= '0;
        end else if ((state == ST_IDLE) && start_ih) begin
            run_val <= '0;
            run_idx <= '0;
        end else if (pop) begin
            // Strictly greater replaces, so ties keep the earlier (lower) index.
            if (head_gt) begin
                run_val <= fifo_data[rd_ptr];
                run_idx <= fifo_idx[rd_ptr];
            end
            if (head_last) begin
                peak_val_od <= head_gt ? fifo_data[rd_ptr] : run_val;
                peak_idx_od <= head_gt ? fifo_idx[rd_ptr]  : run_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fgyrus_res_reader.md
FGYRUS_RES_READER -- requirements
Module: fgyrus_res_reader

Interface
REQ-001 SHALL have parameter P_32B_W, default 32: FFT result word width.
REQ-002 SHALL have parameter P_FFT_RES_RAM_ADDR_W, default 7: FFT Res RAM address width.
REQ-003 SHALL have parameter P_NUM_BINS, default 128: bins read per frame (1..2^P_FFT_RES_RAM_ADDR_W).
REQ-004 clk_ir  in  1  single clock; all logic on its rising edge.
REQ-005 rst_ih  in  1  reset, synchronous, active-high.
REQ-006 start_ih  in  1  1-cycle pulse, request a frame read (driven from FFT-done/irq).
REQ-007 fft_res_rd_addr_od  out  P_FFT_RES_RAM_ADDR_W  FFT Res RAM read address.
REQ-008 fft_res_rd_en_oh  out  1  1 -> read issued this cycle.
REQ-009 fft_res_rd_data_id  in  P_32B_W  RAM read data; valid exactly 1 cycle after rd_en.
REQ-010 bin_data_od  out  P_32B_W  streamed bin magnitude.
REQ-011 bin_idx_od  out  P_FFT_RES_RAM_ADDR_W  index of bin_data_od.
REQ-012 bin_valid_oh  out  1  1 -> bin_data_od/bin_idx_od/bin_last_oh valid.
REQ-013 bin_ready_ih  in  1  1 -> sink accepts; transfer = valid & ready.
REQ-014 bin_last_oh  out  1  1 -> current bin is index P_NUM_BINS-1.
REQ-015 busy_oh  out  1  1 -> frame in progress.
REQ-016 done_oh  out  1  1-cycle pulse, frame complete.
REQ-017 peak_idx_od  out  P_FFT_RES_RAM_ADDR_W  index of largest bin of last frame.
REQ-018 peak_val_od  out  P_32B_W  value of largest bin of last frame.

Function
REQ-019 FSM states SHALL be IDLE, READ, DRAIN; IDLE->READ on start_ih; READ->DRAIN after read of index P_NUM_BINS-1 issued; DRAIN->IDLE on transfer of last bin.
REQ-020 start_ih outside IDLE SHALL be ignored (no restart, no queueing).
REQ-021 Reads SHALL be issued in ascending address order 0..P_NUM_BINS-1, each exactly once per frame.
REQ-022 Output buffer SHALL be a 2-entry FIFO of {data, idx, last}; RAM data SHALL be written into it the cycle after rd_en.
REQ-023 A read SHALL be issued in READ only when fifo_count + reads_in_flight - pop < 2, pop = bin_valid_oh & bin_ready_ih; FIFO SHALL never overflow.
REQ-024 With bin_ready_ih held 1, SHALL sustain one bin per cycle after initial latency.
REQ-025 Latency: start_ih in cycle 0 -> rd_en/addr 0 in cycle 1 -> bin_valid_oh=1 with idx 0 in cycle 3.
REQ-026 While bin_valid_oh=1 and bin_ready_ih=0, bin_data_od, bin_idx_od, bin_last_oh SHALL hold stable.
REQ-027 bin_valid_oh SHALL equal (fifo_count != 0); outputs SHALL come from FIFO head.
REQ-028 busy_oh SHALL be 1 from cycle after start accepted until cycle of last transfer inclusive, else 0.
REQ-029 done_oh SHALL pulse the cycle after last-bin transfer, with busy_oh=0 and FSM in IDLE.
REQ-030 Peak tracker SHALL compare each transferred bin as unsigned; strictly greater replaces; ties keep lower index; running peak cleared at frame start.
REQ-031 peak_idx_od/peak_val_od SHALL update only on the done_oh cycle and hold until next done_oh.
REQ-032 fft_res_rd_addr_od SHALL hold last issued address when rd_en=0.
REQ-033 P_NUM_BINS=1: single read, bin_last_oh=1 on idx 0.

Reset
REQ-034 rst_ih=1 at a clock edge SHALL force IDLE, flush FIFO, discard in-flight read data, clear running peak, regardless of state.
REQ-035 Reset values: all outputs 0 (addr 0, rd_en 0, bin_valid 0, last 0, busy 0, done 0, peak_idx 0, peak_val 0).
REQ-036 Data returning the cycle after reset SHALL NOT enter the FIFO.

Verification
REQ-037 Ready held 1, RAM[i]=i*3, start at cycle 0 -> bins idx 0..127 on cycles 3..130, data i*3, last on idx 127, done_oh cycle 131, peak_idx 127, peak_val 381.
REQ-038 Ready toggled 1/0 each cycle, random ready stalls of 1-10 cycles -> 128 bins in order, no loss/duplication, outputs stable while stalled, fifo never >2.
REQ-039 RAM[5]=RAM[9]=0xFFFF_FFFF, rest 0 -> peak_idx 5, peak_val 0xFFFF_FFFF.
REQ-040 Second start_ih at cycle 10 of a frame -> ignored; exactly 128 bins and one done_oh.
REQ-041 rst_ih at cycle 50 mid-frame with ready=0 -> next cycle all outputs 0, FSM IDLE; subsequent start yields full clean frame from idx 0.
REQ-042 P_NUM_BINS=1, start -> one bin idx 0 with last=1 on cycle 3 (ready=1), done_oh cycle 4.
